mem_control_seq: RTL

- Parametrised, self-sequencing memory controller for the non-power-of-two NTT bank array.
- For NUM_BANKS banks of depth DEPTH it generates, per NTT stage:
  - per-bank addresses;
  - a rotating write-enable window;
  - the two cyclic-shift values for the crossbar/rotation network.
- Accepts a start/stage command, counts incr steps itself, and pulses done at stage end.
- Adds a reverse (inverse-NTT) rotation mode and idle gating of write enables.

---
 rtl/ntt_mem_pkg.sv | 37 +++
 rtl/mem_control_seq_if.sv | 30 +++
 rtl/bank_addr_ctr.sv | 33 +++
 rtl/mod_add.sv | 17 +
 rtl/mod_sub.sv | 14 +
 rtl/mem_control_seq.sv | 148 ++++++++++++++
 6 files changed

// File: rtl/ntt_mem_pkg.sv
// Shared encodings and default geometry for the NTT bank-array memory controller.
// The defaults describe a 257-bank array with 85 words per bank.
package ntt_mem_pkg;

    typedef enum logic [1:0] {
        MODE_LIN     = 2'd0,
        MODE_ROT_FWD = 2'd1,
        MODE_ROT_REV = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_NUM_BANKS = 257;
    localparam int DEF_DEPTH     = 85;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_SHIFT_W   = 9;
    localparam int DEF_WIN       = 85;
    localparam int DEF_SHIFT_M0  = 1;
    localparam int DEF_SHIFT_M1  = 85;
    localparam int DEF_STEPS_M0  = 85;
    localparam int DEF_STEPS_M1  = 257;
    localparam int STEP_CNT_W    = 9;

    // Stage codes 2 and 3 both select the inverse rotation.
    function automatic mode_t decode_mode(input logic [1:0] stage);
        case (stage)
            2'd0:    return MODE_LIN;
            2'd1:    return MODE_ROT_FWD;
            default: return MODE_ROT_REV;
        endcase
    endfunction

endpackage

// File: rtl/mem_control_seq_if.sv
// Command/status bundle between a stage sequencer (master) and the
// memory controller (slave).
interface mem_control_seq_if
    import ntt_mem_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int SHIFT_W   = DEF_SHIFT_W
);
    logic                        start;
    logic [1:0]                  stage;
    logic                        incr;
    logic                        busy;
    logic                        done;
    logic [STEP_CNT_W-1:0]       step_cnt;
    logic [NUM_BANKS*ADDR_W-1:0] addr;
    logic [NUM_BANKS-1:0]        we;
    logic [SHIFT_W-1:0]          cs1_shift;
    logic [SHIFT_W-1:0]          cs2_shift;

    modport master (
        output start, stage, incr,
        input  busy, done, step_cnt, addr, we, cs1_shift, cs2_shift
    );

    modport slave (
        input  start, stage, incr,
        output busy, done, step_cnt, addr, we, cs1_shift, cs2_shift
    );
endinterface

// File: rtl/bank_addr_ctr.sv
// One wrapping address counter per bank; a bank advances on step when its own
// enable or the global all_en override is set.
module bank_addr_ctr
    import ntt_mem_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        step,
    input  logic                        all_en,
    input  logic [NUM_BANKS-1:0]        en,
    output logic [NUM_BANKS*ADDR_W-1:0] addr
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [ADDR_W-1:0] addr_reg;

        always_ff @(posedge clk) begin
            if (reset || clear) begin
                addr_reg <= '0;
            end else if (step && (all_en || en[gi])) begin
                addr_reg <= (addr_reg == LAST) ? '0 : addr_reg + ADDR_W'(1);
            end
        end

        assign addr[gi*ADDR_W +: ADDR_W] = addr_reg;
    end
endmodule

// File: rtl/mod_add.sv
// Modular addition for operands already reduced below MODULUS; one
// conditional subtraction is enough.
module mod_add #(
    parameter int WIDTH   = 9,
    parameter int MODULUS = 257
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    localparam logic [WIDTH:0] MOD = (WIDTH+1)'(MODULUS);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};
    assign y   = (sum >= MOD) ? WIDTH'(sum - MOD) : WIDTH'(sum);
endmodule

// File: rtl/mod_sub.sv
// Modular subtraction for operands already reduced below MODULUS; a borrow
// is repaired by adding the modulus back once.
module mod_sub #(
    parameter int WIDTH   = 9,
    parameter int MODULUS = 257
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    localparam logic [WIDTH:0] MOD = (WIDTH+1)'(MODULUS);

    assign y = (a >= b) ? (a - b) : WIDTH'({1'b0, a} + MOD - {1'b0, b});
endmodule

// File: rtl/mem_control_seq.sv
// Self-sequencing NTT bank-array controller: per stage it steps bank addresses,
// rotates the write-enable window and produces the crossbar shift pair.
module mem_control_seq
    import ntt_mem_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int SHIFT_W   = DEF_SHIFT_W,
    parameter int WIN       = DEF_WIN,
    parameter int SHIFT_M0  = DEF_SHIFT_M0,
    parameter int SHIFT_M1  = DEF_SHIFT_M1,
    parameter int STEPS_M0  = DEF_STEPS_M0,
    parameter int STEPS_M1  = DEF_STEPS_M1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             soft_reset,
    mem_control_seq_if.slave bus
);
    localparam logic [STEP_CNT_W-1:0] STEPS_LIN = STEP_CNT_W'(STEPS_M0);
    localparam logic [STEP_CNT_W-1:0] STEPS_ROT = STEP_CNT_W'(STEPS_M1);
    localparam logic [SHIFT_W-1:0]    M0        = SHIFT_W'(SHIFT_M0);
    localparam logic [SHIFT_W-1:0]    M1        = SHIFT_W'(SHIFT_M1);
    localparam logic [NUM_BANKS-1:0]  WIN_INIT  = {NUM_BANKS{1'b1}} >> (NUM_BANKS - WIN);
    localparam int                    ROT_OFS   = SHIFT_M1 % NUM_BANKS;

    logic                  srst;
    state_t                state_reg, state_next;
    mode_t                 mode_reg, mode_next;
    logic [STEP_CNT_W-1:0] step_cnt_reg, step_cnt_next;
    logic [SHIFT_W-1:0]    cs2_reg, cs2_next, cs1_reg, cs1_next;
    logic [SHIFT_W-1:0]    cs2_add, cs2_sub;
    logic [NUM_BANKS-1:0]  win_reg, win_next, win_fwd, win_rev;
    logic [NUM_BANKS-1:0]  we_reg, we_next;
    logic                  busy_reg, busy_next, done_reg, done_next;
    logic                  start_acc, incr_acc;

    assign srst = reset | soft_reset;

    mod_add #(.WIDTH(SHIFT_W), .MODULUS(NUM_BANKS)) u_cs2_add (
        .a(cs2_reg), .b(M1), .y(cs2_add));
    mod_sub #(.WIDTH(SHIFT_W), .MODULUS(NUM_BANKS)) u_cs2_sub (
        .a(cs2_reg), .b((mode_reg == MODE_LIN) ? M0 : M1), .y(cs2_sub));
    // 0 - cs2 mod N gives exactly the complementary shift, including the 0 case.
    mod_sub #(.WIDTH(SHIFT_W), .MODULUS(NUM_BANKS)) u_cs1 (
        .a('0), .b(cs2_next), .y(cs1_next));

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_win
        assign win_fwd[gi] = win_reg[(gi + ROT_OFS) % NUM_BANKS];
        assign win_rev[gi] = win_reg[(gi + NUM_BANKS - ROT_OFS) % NUM_BANKS];
    end

    always_comb begin
        state_next    = state_reg;
        mode_next     = mode_reg;
        step_cnt_next = step_cnt_reg;
        cs2_next      = cs2_reg;
        win_next      = win_reg;
        start_acc     = 1'b0;
        incr_acc      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    start_acc     = 1'b1;
                    state_next    = ST_RUN;
                    mode_next     = decode_mode(bus.stage);
                    step_cnt_next = '0;
                end
            end
            ST_RUN: begin
                if (bus.incr) begin
                    incr_acc      = 1'b1;
                    step_cnt_next = step_cnt_reg + STEP_CNT_W'(1);
                    if (step_cnt_next == ((mode_reg == MODE_LIN) ? STEPS_LIN : STEPS_ROT)) begin
                        state_next = ST_DONE;
                    end
                    case (mode_reg)
                        MODE_LIN:     cs2_next = cs2_sub;
                        MODE_ROT_FWD: begin
                            cs2_next = cs2_add;
                            win_next = win_fwd;
                        end
                        default: begin
                            cs2_next = cs2_sub;
                            win_next = win_rev;
                        end
                    endcase
                end
            end
            default: state_next = ST_IDLE;
        endcase
        busy_next = (state_next == ST_RUN);
        done_next = (state_next == ST_DONE);
        we_next   = '0;
        if (state_next == ST_RUN) begin
            we_next = (mode_next == MODE_LIN) ? '1 : win_next;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            mode_reg     <= MODE_LIN;
            step_cnt_reg <= '0;
            cs2_reg      <= '0;
            cs1_reg      <= '0;
            win_reg      <= WIN_INIT;
            we_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            mode_reg     <= mode_next;
            step_cnt_reg <= step_cnt_next;
            cs2_reg      <= cs2_next;
            cs1_reg      <= cs1_next;
            win_reg      <= win_next;
            we_reg       <= we_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    // Rotating modes advance only the banks whose write enable is live this cycle.
    bank_addr_ctr #(.NUM_BANKS(NUM_BANKS), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_addr (
        .clk    (clk),
        .reset  (srst),
        .clear  (start_acc),
        .step   (incr_acc),
        .all_en (mode_reg == MODE_LIN),
        .en     (we_reg),
        .addr   (bus.addr)
    );

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.step_cnt  = step_cnt_reg;
    assign bus.we        = we_reg;
    assign bus.cs1_shift = cs1_reg;
    assign bus.cs2_shift = cs2_reg;
endmodule
